imem_port_arbiter: RTL
======================

Name: imem_port_arbiter

Overview:
- Shares one single-ported, synchronous-read program/data memory between two requesters: instruction fetch (IF) and the data load/store unit (D).
- Sits between the CPU front end / memory stage and the unified memory macro.
- Issues at most one memory access per cycle and routes the read data back to its owner one cycle later.
- Prevents fetch starvation with a bounded data-priority counter.

Parameters:
- ADDR_WIDTH, 32: byte-address width of both requesters and of mem_addr.
- DATA_WIDTH, 32: word width; byte enables are DATA_WIDTH/8 bits.
- STARVE_LIMIT, 4: maximum consecutive data grants while IF is waiting; the next contended cycle goes to IF. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_ready  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch data valid (registered).
- if_rdata  out  DATA_WIDTH  fetch data.
- d_req  in  1  data request; held with the other d_* inputs until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  store data.
- d_be  in  DATA_WIDTH/8  store byte enables.
- d_ready  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  load data valid; never asserted for stores.
- d_rdata  out  DATA_WIDTH  load data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  word address: {2'b0, addr[ADDR_WIDTH-1:2]} of the granted requester.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_be  out  DATA_WIDTH/8  byte enables.
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after a read with mem_en=1.

Behaviour:
- Arbitration is combinational and grants at most one requester per cycle.
  - Only one requester active: that requester is granted.
  - Both active: D wins if starve_cnt < STARVE_LIMIT; otherwise IF wins.
  - Neither active: mem_en=0, and mem_we/mem_addr/mem_wdata/mem_be = 0.
- Granted IF drives: mem_en=1, mem_we=0, mem_be all ones, mem_wdata=0.
- Granted D drives: mem_en=1, mem_we=d_we, mem_be=d_be, mem_wdata=d_wdata.
- Address bits [1:0] are dropped; no misalignment check is made.
- starve_cnt (4 bits) updates on each clock edge:
  - cleared when IF is granted or if_req=0;
  - incremented when D is granted while if_req=1;
  - saturates at STARVE_LIMIT.
- Response FSM (owner register):
  - States: IDLE, RESP_IF, RESP_D.
  - Next state: IF granted → RESP_IF; D load granted → RESP_D; store or no grant → IDLE.
  - In RESP_IF: if_rvalid=1, if_rdata=mem_rdata.
  - In RESP_D: d_rvalid=1, d_rdata=mem_rdata.
  - Otherwise both rvalid=0 and both rdata=0.
  - Back-to-back grants are allowed every cycle; the response for cycle N appears in cycle N+1 regardless of cycle N+1's grant.
- Latency: request to rvalid is exactly 1 cycle when uncontended. A store completes in the grant cycle.
- Reset (rst_n=0, asynchronous):
  - FSM → IDLE, starve_cnt=0, if_rvalid=d_rvalid=0, rdata outputs 0.
  - Combinational grants and mem_* outputs are forced to 0 while reset is asserted.
  - A response in flight at reset is discarded, not replayed.
- Requesters must not change address or data while req=1 and ready=0. The arbiter does not check this; the bench asserts it.

Test Plan:
- Reset: rst_n=0 mid-stream with IF grant pending → all outputs 0 immediately. First edge after release with if_req=1, if_addr=0x10 → mem_addr=0x4 and if_ready=1; next cycle if_rvalid=1 with if_rdata = word 4.
- Uncontended fetch stream: if_addr=0x0,0x4,0x8 on consecutive cycles → if_ready=1 on every cycle; if_rvalid=1 on cycles 1–3 with words 0,1,2.
- Contention with STARVE_LIMIT=4: if_req and d_req (load) held high continuously → grants D,D,D,D,IF,D,D,D,D,IF…; starve_cnt sequence 1,2,3,4,0.
- Store: d_req=1, d_we=1, d_addr=0x20, d_be=4'b0011, d_wdata=0xAABBCCDD → mem_we=1, mem_addr=0x8, mem_be=0011; d_rvalid stays 0. Later load of 0x20 returns 0x????CCDD with the upper bytes unchanged.
- Mixed back-to-back: D load at cycle N, IF at N+1 → d_rvalid only at N+1, if_rvalid only at N+2; the two valids never overlap.
- Idle: both req=0 → mem_en=0, no rvalid, starve_cnt=0.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter_if
// Purpose  : Bundles the fetch requester, data requester and memory macro
//            signals of the shared program/data memory port arbiter.
// Modports : slave  - arbiter view (takes requests, drives the memory)
//            master - environment view (requesters plus memory macro)
// Signals  : if_req/if_addr/if_ready/if_rvalid/if_rdata      fetch port
//            d_req/d_we/d_addr/d_wdata/d_be/d_ready/
//            d_rvalid/d_rdata                                 data port
//            mem_en/mem_we/mem_addr/mem_wdata/mem_be/mem_rdata memory side
// Revision : 1.0 - initial release
// ============================================================================
interface imem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    if_req;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic                    if_ready;
  logic                    if_rvalid;
  logic [DATA_WIDTH-1:0]   if_rdata;

  logic                    d_req;
  logic                    d_we;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic [DATA_WIDTH/8-1:0] d_be;
  logic                    d_ready;
  logic                    d_rvalid;
  logic [DATA_WIDTH-1:0]   d_rdata;

  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter
// Purpose  : Shares one single-ported synchronous-read memory between the
//            instruction fetch port and the data load/store port. One access
//            per cycle; read data is routed back to its owner one cycle later.
//            A bounded counter stops data traffic from starving fetch.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - imem_port_arbiter_if.slave (fetch, data, memory signals)
// Revision : 1.0 - initial release
// ============================================================================
module imem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  wire                   clk,
  input  wire                   rst_n,
  imem_port_arbiter_if.slave    bus
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_starve_cnt;

  logic w_d_gnt;
  logic w_if_gnt;

  // Data wins unless fetch is waiting and has already lost STARVE_LIMIT times
  // in a row. Both grants are held low while reset is asserted.
  always_comb begin
    w_d_gnt  = 1'b0;
    w_if_gnt = 1'b0;
    if (rst_n) begin
      w_d_gnt  = bus.d_req && (!bus.if_req || (r_starve_cnt < c_starve_limit));
      w_if_gnt = bus.if_req && !w_d_gnt;
    end
  end

  // Memory request mux; word address drops the byte-offset bits.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (w_if_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = {2'b00, bus.if_addr[ADDR_WIDTH-1:2]};
      bus.mem_be   = '1;
    end else if (w_d_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = {2'b00, bus.d_addr[ADDR_WIDTH-1:2]};
      bus.mem_wdata = bus.d_wdata;
      bus.mem_be    = bus.d_be;
    end
  end

  assign bus.if_ready = w_if_gnt;
  assign bus.d_ready  = w_d_gnt;

  // Owner register and starvation counter. The owner recorded in cycle N
  // steers mem_rdata in cycle N+1, independent of the grant in N+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= 4'd0;
    end else begin
      if (w_if_gnt) begin
        r_state <= RESP_IF;
      end else if (w_d_gnt && !bus.d_we) begin
        r_state <= RESP_D;
      end else begin
        r_state <= IDLE;
      end

      if (w_if_gnt || !bus.if_req) begin
        r_starve_cnt <= 4'd0;
      end else if (w_d_gnt && (r_starve_cnt < c_starve_limit)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  assign bus.if_rvalid = (r_state == RESP_IF);
  assign bus.d_rvalid  = (r_state == RESP_D);
  assign bus.if_rdata  = (r_state == RESP_IF) ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (r_state == RESP_D)  ? bus.mem_rdata : '0;

endmodule
`default_nettype wire
